hazard_fwd_unit: RTL

//  Parametrised hazard controller for the core pipeline.
//  - Forwards operands for NSRC ID read ports from NSTG later stages (EX first, then MEM, WB, ...).
//  - Detects load-use hazards.
//  - Keeps a per-register scoreboard for long-latency writers (divider) and stalls ID on RAW/WAW against it.
//  - Sits between ID decode and the ID/EX pipeline register.

---
 rtl/hazard_fwd_unit_if.sv | 52 +++++
 rtl/hazard_fwd_unit.sv | 127 ++++++++++++
 2 files changed

// File: rtl/hazard_fwd_unit_if.sv
// Signal bundle between ID decode, the later pipe stages and the hazard unit.
// Perf counter outputs exist only when HAZARD_PERF_EN is defined.
interface hazard_fwd_unit_if #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int NSTG   = 3
);
    localparam int SEL_W = $clog2(NSTG + 1);

    logic [NSRC*ADDR_W-1:0] id_raddr_i;
    logic [NSRC-1:0]        id_rvalid_i;
    logic [ADDR_W-1:0]      id_waddr_i;
    logic                   id_we_i;
    logic [NSTG*ADDR_W-1:0] stg_waddr_i;
    logic [NSTG-1:0]        stg_we_i;
    logic                   ex_is_load_i;
    logic                   long_issue_i;
    logic [ADDR_W-1:0]      long_waddr_i;
    logic                   long_done_i;
    logic [ADDR_W-1:0]      long_done_waddr_i;
    logic                   flush_i;
    logic [NSRC*SEL_W-1:0]  fwd_sel_o;
    logic                   stall_o;
    logic [1:0]             state_o;
    logic                   sb_busy_o;
`ifdef HAZARD_PERF_EN
    logic [31:0]            perf_load_stall_o;
    logic [31:0]            perf_long_stall_o;
`endif

    modport slave (
        input  id_raddr_i, id_rvalid_i, id_waddr_i, id_we_i,
        input  stg_waddr_i, stg_we_i, ex_is_load_i,
        input  long_issue_i, long_waddr_i,
        input  long_done_i, long_done_waddr_i, flush_i,
        output fwd_sel_o, stall_o, state_o, sb_busy_o
`ifdef HAZARD_PERF_EN
        , output perf_load_stall_o, perf_long_stall_o
`endif
    );

    modport master (
        output id_raddr_i, id_rvalid_i, id_waddr_i, id_we_i,
        output stg_waddr_i, stg_we_i, ex_is_load_i,
        output long_issue_i, long_waddr_i,
        output long_done_i, long_done_waddr_i, flush_i,
        input  fwd_sel_o, stall_o, state_o, sb_busy_o
`ifdef HAZARD_PERF_EN
        , input perf_load_stall_o, perf_long_stall_o
`endif
    );
endinterface

// File: rtl/hazard_fwd_unit.sv
// Operand forwarding, load-use and long-latency scoreboard hazard control.
// Optional stall-cycle perf counters under HAZARD_PERF_EN.
module hazard_fwd_unit #(
    parameter int ADDR_W = 5,
    parameter int NSRC   = 2,
    parameter int NSTG   = 3
) (
    input logic              clk,
    input logic              rst,
    hazard_fwd_unit_if.slave bus
);
    localparam int SEL_W = $clog2(NSTG + 1);
    localparam int NREG  = 2 ** ADDR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_LONG = 2'd2
    } state_e;

    state_e state_q, state_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [NSRC*SEL_W-1:0] sel;
    logic load_hz, long_hz, stall;

    logic [ADDR_W-1:0] ra [NSRC];
    logic [ADDR_W-1:0] sa [NSTG];

    for (genvar k = 0; k < NSRC; k++) begin : g_ra
        assign ra[k] = bus.id_raddr_i[k*ADDR_W +: ADDR_W];
    end
    for (genvar j = 0; j < NSTG; j++) begin : g_sa
        assign sa[j] = bus.stg_waddr_i[j*ADDR_W +: ADDR_W];
    end

    // Stages scanned oldest to youngest so the youngest match overwrites.
    always_comb begin
        sel     = '0;
        load_hz = 1'b0;
        long_hz = bus.id_we_i & pend_q[bus.id_waddr_i];
        for (int k = 0; k < NSRC; k++) begin
            if (bus.id_rvalid_i[k] && ra[k] != '0) begin
                for (int j = NSTG - 1; j >= 0; j--) begin
                    if (bus.stg_we_i[j] && sa[j] == ra[k])
                        sel[k*SEL_W +: SEL_W] = SEL_W'(j + 1);
                end
                if (bus.ex_is_load_i && bus.stg_we_i[0] && sa[0] == ra[k])
                    load_hz = 1'b1;
                if (pend_q[ra[k]])
                    long_hz = 1'b1;
            end
        end
    end

    assign stall = rst & (load_hz | long_hz) & ~bus.flush_i;

    // Issue applied after clear so a same-cycle reissue keeps the bit.
    always_comb begin
        pend_d = pend_q;
        if (bus.long_done_i)
            pend_d[bus.long_done_waddr_i] = 1'b0;
        if (bus.long_issue_i)
            pend_d[bus.long_waddr_i] = 1'b1;
        pend_d[0] = 1'b0;
    end

    always_comb begin
        state_d = S_IDLE;
        priority case (1'b1)
            bus.flush_i: state_d = S_IDLE;
            long_hz:     state_d = S_LONG;
            load_hz:     state_d = S_LOAD;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_q  <= '0;
            state_q <= S_IDLE;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
        end
    end

    assign bus.fwd_sel_o = rst ? sel : '0;
    assign bus.stall_o   = stall;
    assign bus.state_o   = state_q;
    assign bus.sb_busy_o = |pend_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_load_q, perf_load_d;
    logic [31:0] perf_long_q, perf_long_d;

    always_comb begin
        perf_load_d = perf_load_q;
        perf_long_d = perf_long_q;
        if (stall) begin
            if (long_hz) begin
                if (perf_long_q != '1)
                    perf_long_d = perf_long_q + 32'd1;
            end else if (perf_load_q != '1) begin
                perf_load_d = perf_load_q + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_load_q <= '0;
            perf_long_q <= '0;
        end else begin
            perf_load_q <= perf_load_d;
            perf_long_q <= perf_long_d;
        end
    end

    assign bus.perf_load_stall_o = perf_load_q;
    assign bus.perf_long_stall_o = perf_long_q;
`endif

    issue_in_stall_a: assert property (
        @(posedge clk) disable iff (!rst)
        !(bus.long_issue_i && stall)
    );
endmodule
